// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit.
package multicycle_controller_pkg;

    localparam int unsigned OPC_W   = 7;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_BEQ      = 4'd8,
        S_ERROR    = 4'd9
    } state_t;

    localparam logic [OPC_W-1:0] OP_LW    = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_SW    = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_RTYPE = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_BEQ   = 7'b1100011;

    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] IMM_I = 2'b00;
    localparam logic [SEL_W-1:0] IMM_S = 2'b01;
    localparam logic [SEL_W-1:0] IMM_B = 2'b10;

    // Immediate format selected purely from the opcode.
    function automatic logic [SEL_W-1:0] imm_sel(input logic [OPC_W-1:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath signal bundle.
interface multicycle_controller_if;

    logic [multicycle_controller_pkg::OPC_W-1:0]   opcode;
    logic                                          zero;
    logic                                          mem_ready;
    logic                                          mem_req;
    logic                                          pc_write;
    logic                                          ir_write;
    logic                                          reg_write;
    logic                                          mem_write;
    logic                                          adr_src;
    logic [multicycle_controller_pkg::SEL_W-1:0]   result_src;
    logic [multicycle_controller_pkg::SEL_W-1:0]   alu_src_a;
    logic [multicycle_controller_pkg::SEL_W-1:0]   alu_src_b;
    logic [multicycle_controller_pkg::SEL_W-1:0]   alu_op;
    logic [multicycle_controller_pkg::SEL_W-1:0]   imm_src;
    logic [multicycle_controller_pkg::STATE_W-1:0] state_o;
    logic                                          illegal_op;
    logic                                          timeout_err;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, pc_write, ir_write, reg_write, mem_write, adr_src,
               result_src, alu_src_a, alu_src_b, alu_op, imm_src,
               state_o, illegal_op, timeout_err
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, pc_write, ir_write, reg_write, mem_write, adr_src,
               result_src, alu_src_a, alu_src_b, alu_op, imm_src,
               state_o, illegal_op, timeout_err
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled memory cycles and flags when the limit is hit.
module mem_wait_timer
    import multicycle_controller_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic wait_i,
    output logic timeout_o
);

    logic [CNT_W-1:0] count_q, count_d;

    // Clear on any state change, otherwise count stalled cycles.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (wait_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A ready arriving on the limit cycle suppresses the timeout.
    assign timeout_o = wait_i && (count_q == CNT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle RISC-V datapath with memory timeout.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_controller_if.master bus
);

    state_t state_q, state_d;
    logic   wait_c;
    logic   clear_c;
    logic   timeout_c;

    assign wait_c  = ((state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                      (state_q == S_MEMWRITE)) && !bus.mem_ready;
    assign clear_c = (state_d != state_q);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (clear_c),
        .wait_i    (wait_c),
        .timeout_o (timeout_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_d         = state_q;
        bus.mem_req     = 1'b0;
        bus.pc_write    = 1'b0;
        bus.ir_write    = 1'b0;
        bus.reg_write   = 1'b0;
        bus.mem_write   = 1'b0;
        bus.adr_src     = 1'b0;
        bus.result_src  = RES_ALUOUT;
        bus.alu_src_a   = SRCA_PC;
        bus.alu_src_b   = SRCB_RS2;
        bus.alu_op      = ALUOP_ADD;
        bus.imm_src     = imm_sel(bus.opcode);
        bus.state_o     = state_q;
        bus.illegal_op  = 1'b0;
        bus.timeout_err = 1'b0;

        case (state_q)
            S_FETCH: begin
                bus.mem_req    = 1'b1;
                bus.ir_write   = bus.mem_ready;
                bus.pc_write   = bus.mem_ready;
                bus.alu_src_b  = SRCB_FOUR;
                bus.result_src = RES_ALURESULT;
                if (bus.mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout_c) begin
                    state_d = S_ERROR;
                end
            end
            S_DECODE: begin
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_IMM;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECR;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        bus.illegal_op = 1'b1;
                        state_d        = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_IMM;
                if (bus.opcode == OP_LW) begin
                    state_d = S_MEMREAD;
                end else if (bus.opcode == OP_SW) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMREAD: begin
                bus.mem_req = 1'b1;
                bus.adr_src = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout_c) begin
                    state_d = S_ERROR;
                end
            end
            S_MEMWB: begin
                bus.result_src = RES_DATA;
                bus.reg_write  = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEMWRITE: begin
                bus.mem_req   = 1'b1;
                bus.adr_src   = 1'b1;
                bus.mem_write = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout_c) begin
                    state_d = S_ERROR;
                end
            end
            S_EXECR: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_op    = ALUOP_FUNCT;
                state_d       = S_ALUWB;
            end
            S_ALUWB: begin
                bus.reg_write = 1'b1;
                state_d       = S_FETCH;
            end
            S_BEQ: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_op    = ALUOP_SUB;
                bus.pc_write  = bus.zero;
                state_d       = S_FETCH;
            end
            S_ERROR: begin
                bus.timeout_err = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter: MEM_TIMEOUT, 15, max consecutive cycles a memory state may wait on mem_ready before an error is raised (legal range 1..255).
REQ-002 SHALL have one clock, and reset is synchronous and active-high; ports are named clk and reset.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 opcode  in  7  instr[6:0] from the instruction register.
REQ-006 zero  in  1  ALU zero flag.
REQ-007 mem_ready  in  1  memory completes the current access this cycle.
REQ-008 mem_req  out  1  memory access request.
REQ-009 pc_write, ir_write, reg_write, mem_write, adr_src  out  1 each  datapath strobes and selects.
REQ-010 result_src, alu_src_a, alu_src_b, alu_op, imm_src  out  2 each  datapath mux selects and ALU op class.
REQ-011 state_o  out  4  current state encoding, for debug.
REQ-012 illegal_op  out  1  one-cycle pulse on an unsupported opcode.
REQ-013 timeout_err  out  1  sticky memory-timeout flag.

Function
REQ-014 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, ALUWB, BEQ, ERROR.
REQ-015 Transitions SHALL be:
- FETCH -> DECODE on mem_ready; otherwise FETCH.
- DECODE -> MEMADR on lw or sw; EXECR on R-type; BEQ on beq; FETCH on any other opcode.
- MEMADR -> MEMREAD on lw; MEMWRITE on sw.
- MEMREAD -> MEMWB on mem_ready.
- MEMWRITE -> FETCH on mem_ready.
- MEMWB, ALUWB, BEQ -> FETCH.
- EXECR -> ALUWB.
REQ-016 Opcodes SHALL be: lw 0000011, sw 0100011, R-type 0110011, beq 1100011.
REQ-017 Defaults SHALL be all strobes 0 and all selects 00; each state overrides only the fields listed:
- FETCH: mem_req=1, ir_write=mem_ready, alu_src_b=10, result_src=10, pc_write=mem_ready.
- DECODE: alu_src_a=01, alu_src_b=01.
- MEMADR: alu_src_a=10, alu_src_b=01.
- MEMREAD: mem_req=1, adr_src=1.
- MEMWB: result_src=01, reg_write=1.
- MEMWRITE: mem_req=1, adr_src=1, mem_write=1.
- EXECR: alu_src_a=10, alu_op=10.
- ALUWB: reg_write=1.
- BEQ: alu_src_a=10, alu_op=01, pc_write=zero.
REQ-018 imm_src SHALL be combinational from opcode in every state: sw 01, beq 10, otherwise 00.
REQ-019 illegal_op SHALL pulse exactly one cycle, in DECODE, when opcode is not one of the four supported codes.
REQ-020 An 8-bit wait counter SHALL clear on every state change and increment each cycle spent in FETCH, MEMREAD or MEMWRITE with mem_ready=0.
REQ-021 When the wait counter equals MEM_TIMEOUT and mem_ready=0, the next state SHALL be ERROR.
REQ-022 mem_ready=1 in the same cycle the count reaches MEM_TIMEOUT SHALL take priority: the normal transition is taken and no error is raised.
REQ-023 ERROR SHALL be absorbing until reset, with all strobes 0, mem_req=0 and timeout_err=1.
REQ-024 mem_write and reg_write SHALL never be asserted in the same cycle.

Reset
REQ-025 On reset the state SHALL become FETCH, the wait counter 0, and timeout_err 0.
REQ-026 Reset asserted in any state, including mid-access or ERROR, SHALL take effect at the next edge; outputs then follow the FETCH values, so mem_req=1 in the first cycle after reset.

Structure
REQ-027 The shared package SHALL hold the state enum (4-bit), the opcode constants, and the select encodings for result_src, alu_src_a, alu_src_b and alu_op.
REQ-028 The wait counter and timeout compare SHALL form one sub-module, mem_wait_timer.

Verification
REQ-029 lw with mem_ready tied to 1 -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB; exactly one reg_write with result_src=01; the cycle is 5 cycles long.
REQ-030 sw with mem_ready low for 3 cycles in MEMWRITE -> mem_write held 4 cycles, then FETCH; reg_write stays 0 throughout.
REQ-031 beq with zero=1 -> pc_write=1 in BEQ; with zero=0 -> pc_write=0; both cases are 3 cycles.
REQ-032 opcode 0010011 -> illegal_op pulses for 1 cycle in DECODE, next state FETCH, no strobes asserted.
REQ-033 MEM_TIMEOUT=4 with mem_ready stuck at 0 in FETCH -> ERROR after 5 cycles, timeout_err=1 sticky; reset -> FETCH with timeout_err=0. Also: mem_ready arriving on the limit cycle -> DECODE with no error.
